// File: rtl/tlb_op_sequencer_if.sv
// tlb_op_sequencer_if: pipeline/CP0 and MMU handshake signals of the TLB op sequencer
interface tlb_op_if;
    logic       Op_Valid_I;
    logic [5:0] Op_Func_I;
    logic       Exc_Flush_I;
    logic       MMU_Ack_I;
    logic       MMU_Matched_I;
    logic       Op_Ready_O;
    logic       Stall_O;
    logic       MMU_Req_O;
    logic [1:0] MMU_Func_O;
    logic       MMU_Random_O;
    logic       Cp0_LoadEntry_O;
    logic       Cp0_LoadIndex_O;
    logic       Probe_Miss_O;
    logic       Done_O;
    logic       Timeout_O;
    logic       Illegal_O;

    modport slave (
        input  Op_Valid_I, Op_Func_I, Exc_Flush_I, MMU_Ack_I, MMU_Matched_I,
        output Op_Ready_O, Stall_O, MMU_Req_O, MMU_Func_O, MMU_Random_O,
               Cp0_LoadEntry_O, Cp0_LoadIndex_O, Probe_Miss_O, Done_O, Timeout_O, Illegal_O
    );

    modport master (
        output Op_Valid_I, Op_Func_I, Exc_Flush_I, MMU_Ack_I, MMU_Matched_I,
        input  Op_Ready_O, Stall_O, MMU_Req_O, MMU_Func_O, MMU_Random_O,
               Cp0_LoadEntry_O, Cp0_LoadIndex_O, Probe_Miss_O, Done_O, Timeout_O, Illegal_O
    );
endinterface

// File: rtl/tlb_op_sequencer.sv
// tlb_op_sequencer: sequences TLBR/TLBWI/TLBWR/TLBP between pipeline, CP0 and MMU with bounded ack wait
module tlb_op_sequencer #(
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input logic   Clk,
    input logic   Reset_N,
    tlb_op_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, COMMIT} state_e;

    localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT);

    state_e          state_q;
    logic [1:0]      func_q;
    logic            random_q;
    logic            matched_q;
    logic [TO_W-1:0] cnt_q;
    logic [1:0]      dec_func;
    logic            accept;
    logic            abort;
    logic            expire;
    logic            in_flight;
    logic            commit;

    // Decode the CP0 function and derive accept / flush-abort / timeout conditions
    always_comb begin
        dec_func = (bus.Op_Func_I == 6'b000001) ? 2'b01 :
                   (bus.Op_Func_I == 6'b000010 || bus.Op_Func_I == 6'b000110) ? 2'b10 :
                   (bus.Op_Func_I == 6'b001000) ? 2'b11 : 2'b00;
        accept    = state_q == IDLE && bus.Op_Valid_I && dec_func != 2'b00 && !bus.Exc_Flush_I;
        abort     = state_q == WAIT && bus.Exc_Flush_I && func_q != 2'b10;
        expire    = state_q == WAIT && !bus.MMU_Ack_I && !abort && cnt_q == TO_LIM;
        in_flight = state_q == ISSUE || state_q == WAIT;
        commit    = state_q == COMMIT;
    end

    assign bus.Op_Ready_O      = state_q == IDLE;
    assign bus.Stall_O         = in_flight || accept;
    assign bus.MMU_Req_O       = state_q == ISSUE;
    assign bus.MMU_Func_O      = in_flight ? func_q : 2'b00;
    assign bus.MMU_Random_O    = in_flight && random_q;
    assign bus.Cp0_LoadEntry_O = commit && func_q == 2'b01;
    assign bus.Cp0_LoadIndex_O = commit && func_q == 2'b11;
    assign bus.Probe_Miss_O    = commit && func_q == 2'b11 && !matched_q;
    assign bus.Done_O          = commit;
    assign bus.Timeout_O       = expire;
    assign bus.Illegal_O       = state_q == IDLE && bus.Op_Valid_I && dec_func == 2'b00;

    // Operation FSM: capture op, issue once, wait for ack or timeout, commit; TLBW ignores flush
    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            state_q   <= IDLE;
            func_q    <= 2'b00;
            random_q  <= 1'b0;
            matched_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    state_q  <= ISSUE;
                    func_q   <= dec_func;
                    random_q <= bus.Op_Func_I == 6'b000110;
                end
                ISSUE: begin
                    cnt_q   <= '0;
                    state_q <= WAIT;
                end
                WAIT: if (abort) begin
                    state_q <= IDLE;
                end else if (bus.MMU_Ack_I) begin
                    matched_q <= bus.MMU_Matched_I;
                    state_q   <= COMMIT;
                end else if (cnt_q == TO_LIM) begin
                    state_q <= IDLE;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tlb_op_sequencer.sv
// tb_tlb_op_sequencer: table-driven ops with a per-op scoreboard plus reset and back-to-back sequences
module tb_tlb_op_sequencer;
    logic Clk = 1'b0;
    logic Reset_N = 1'b0;

    always #5 Clk = ~Clk;

    tlb_op_if bus();

    tlb_op_sequencer #(.TIMEOUT(4), .TO_W(8)) dut (
        .Clk    (Clk),
        .Reset_N(Reset_N),
        .bus    (bus)
    );

    typedef struct {
        int busy, done, entry, index, miss, tmo;
        logic [1:0] mfunc;
        logic       rnd;
    } exp_t;

    typedef struct {
        logic [5:0] func;
        int         ack_at;
        logic       matched;
        int         flush_at;
        logic       accept;
        logic       illegal;
        exp_t       e;
    } vec_t;

    exp_t sb[$];
    exp_t me;
    vec_t tbl[13];
    int n_chk = 0;
    int n_fail = 0;
    int busy = 0, c_done = 0, c_entry = 0, c_index = 0, c_miss = 0, c_tmo = 0, c_req = 0, fcnt = 0;
    logic [1:0] rq_func = 2'b00;
    logic rq_rnd = 1'b0;

    task automatic chk(input string n, input int a, input int e);
        n_chk++;
        if (a != e) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", n, a, e);
        end
    endtask

    // Accumulate what each op did and compare with the scoreboard once the sequencer is idle again
    always @(negedge Clk) begin
        if (!bus.Op_Ready_O) begin
            busy++;
            c_done  += int'(bus.Done_O);
            c_entry += int'(bus.Cp0_LoadEntry_O);
            c_index += int'(bus.Cp0_LoadIndex_O);
            c_miss  += int'(bus.Probe_Miss_O);
            c_tmo   += int'(bus.Timeout_O);
            if (bus.MMU_Req_O) begin
                c_req++;
                rq_func = bus.MMU_Func_O;
                rq_rnd  = bus.MMU_Random_O;
            end
            if (sb.size() > 0 && bus.MMU_Func_O == sb[0].mfunc) fcnt++;
        end else begin
            chk("idle_pulse", int'(bus.Done_O | bus.Timeout_O | bus.Cp0_LoadEntry_O | bus.Cp0_LoadIndex_O | bus.Probe_Miss_O), 0);
            if (busy > 0) begin
                if (sb.size() == 0) chk("sb_underflow", 1, 0);
                else begin
                    me = sb.pop_front();
                    chk("busy_cycles", busy, me.busy);
                    chk("done", c_done, me.done);
                    chk("load_entry", c_entry, me.entry);
                    chk("load_index", c_index, me.index);
                    chk("probe_miss", c_miss, me.miss);
                    chk("timeout", c_tmo, me.tmo);
                    chk("req_count", c_req, 1);
                    chk("req_func", int'(rq_func), int'(me.mfunc));
                    chk("req_random", int'(rq_rnd), int'(me.rnd));
                    chk("func_held_cycles", fcnt, me.busy - me.done);
                end
                busy = 0; c_done = 0; c_entry = 0; c_index = 0; c_miss = 0; c_tmo = 0; c_req = 0; fcnt = 0;
            end
        end
    end

    task automatic run_vec(input vec_t v, input int idx);
        int last;
        bit fin;
        fin  = 0;
        last = ((v.ack_at > v.flush_at) ? v.ack_at : v.flush_at) + 2;
        @(posedge Clk); #1;
        if (v.accept) sb.push_back(v.e);
        bus.Op_Valid_I    = 1'b1;
        bus.Op_Func_I     = v.func;
        bus.Exc_Flush_I   = v.flush_at == -2;
        bus.MMU_Ack_I     = 1'b0;
        bus.MMU_Matched_I = v.matched;
        @(negedge Clk);
        chk($sformatf("v%0d_stall", idx), int'(bus.Stall_O), int'(v.accept));
        chk($sformatf("v%0d_illegal", idx), int'(bus.Illegal_O), int'(v.illegal));
        chk($sformatf("v%0d_ready", idx), int'(bus.Op_Ready_O), 1);
        for (int c = 1; c <= 30 && !fin; c++) begin
            @(posedge Clk); #1;
            bus.Op_Valid_I  = 1'b0;
            bus.MMU_Ack_I   = v.ack_at >= 0 && c == v.ack_at + 2;
            bus.Exc_Flush_I = v.flush_at >= 0 && c == v.flush_at + 2;
            @(negedge Clk);
            if (bus.Op_Ready_O && c >= last) fin = 1;
        end
        if (!fin) chk($sformatf("v%0d_ready_timeout", idx), 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{6'b000001,  1, 1'b0, -1, 1'b1, 1'b0, '{4, 1, 1, 0, 0, 0, 2'b01, 1'b0}};
        tbl[1]  = '{6'b001000,  0, 1'b0, -1, 1'b1, 1'b0, '{3, 1, 0, 1, 1, 0, 2'b11, 1'b0}};
        tbl[2]  = '{6'b001000,  2, 1'b1, -1, 1'b1, 1'b0, '{5, 1, 0, 1, 0, 0, 2'b11, 1'b0}};
        tbl[3]  = '{6'b000110,  1, 1'b0,  0, 1'b1, 1'b0, '{4, 1, 0, 0, 0, 0, 2'b10, 1'b1}};
        tbl[4]  = '{6'b000010,  0, 1'b0, -1, 1'b1, 1'b0, '{3, 1, 0, 0, 0, 0, 2'b10, 1'b0}};
        tbl[5]  = '{6'b000001,  5, 1'b0, -1, 1'b1, 1'b0, '{6, 0, 0, 0, 0, 1, 2'b01, 1'b0}};
        tbl[6]  = '{6'b000001, -1, 1'b0,  1, 1'b1, 1'b0, '{3, 0, 0, 0, 0, 0, 2'b01, 1'b0}};
        tbl[7]  = '{6'b001000,  3, 1'b0,  0, 1'b1, 1'b0, '{2, 0, 0, 0, 0, 0, 2'b11, 1'b0}};
        tbl[8]  = '{6'b000001,  4, 1'b0, -1, 1'b1, 1'b0, '{7, 1, 1, 0, 0, 0, 2'b01, 1'b0}};
        tbl[9]  = '{6'b000011, -1, 1'b0, -1, 1'b0, 1'b1, '{0, 0, 0, 0, 0, 0, 2'b00, 1'b0}};
        tbl[10] = '{6'b000000, -1, 1'b0, -1, 1'b0, 1'b1, '{0, 0, 0, 0, 0, 0, 2'b00, 1'b0}};
        tbl[11] = '{6'b000010, -1, 1'b0, -2, 1'b0, 1'b0, '{0, 0, 0, 0, 0, 0, 2'b00, 1'b0}};
        tbl[12] = '{6'b000010, -1, 1'b0,  1, 1'b1, 1'b0, '{6, 0, 0, 0, 0, 1, 2'b10, 1'b0}};

        bus.Op_Valid_I = 1'b0; bus.Op_Func_I = 6'b0; bus.Exc_Flush_I = 1'b0;
        bus.MMU_Ack_I = 1'b0; bus.MMU_Matched_I = 1'b0;
        repeat (2) @(negedge Clk);
        chk("rst_ready", int'(bus.Op_Ready_O), 1);
        chk("rst_stall", int'(bus.Stall_O), 0);
        chk("rst_req", int'(bus.MMU_Req_O), 0);
        chk("rst_func", int'(bus.MMU_Func_O), 0);
        chk("rst_done", int'(bus.Done_O), 0);
        Reset_N = 1'b1;

        for (int i = 0; i < 13; i++) run_vec(tbl[i], i);

        // Back-to-back: valid held high, second op accepted in first IDLE cycle after COMMIT
        sb.push_back('{3, 1, 0, 0, 0, 0, 2'b10, 1'b0});
        sb.push_back('{3, 1, 0, 0, 0, 0, 2'b10, 1'b0});
        @(posedge Clk); #1;
        bus.Op_Valid_I = 1'b1; bus.Op_Func_I = 6'b000010; bus.Exc_Flush_I = 1'b0; bus.MMU_Ack_I = 1'b0;
        @(posedge Clk); #1;
        @(posedge Clk); #1; bus.MMU_Ack_I = 1'b1;
        @(posedge Clk); #1; bus.MMU_Ack_I = 1'b0;
        @(negedge Clk);
        chk("b2b_commit_stall", int'(bus.Stall_O), 0);
        chk("b2b_commit_ready", int'(bus.Op_Ready_O), 0);
        @(posedge Clk); #1;
        @(negedge Clk);
        chk("b2b_accept_stall", int'(bus.Stall_O), 1);
        @(posedge Clk); #1; bus.Op_Valid_I = 1'b0;
        @(negedge Clk);
        chk("b2b_second_req", int'(bus.MMU_Req_O), 1);
        @(posedge Clk); #1; bus.MMU_Ack_I = 1'b1;
        @(posedge Clk); #1; bus.MMU_Ack_I = 1'b0;
        repeat (2) @(negedge Clk);

        // Asynchronous reset in the middle of WAIT drops the op
        sb.push_back('{2, 0, 0, 0, 0, 0, 2'b01, 1'b0});
        @(posedge Clk); #1; bus.Op_Valid_I = 1'b1; bus.Op_Func_I = 6'b000001;
        @(posedge Clk); #1; bus.Op_Valid_I = 1'b0;
        @(posedge Clk); #1;
        @(posedge Clk); #1; Reset_N = 1'b0;
        #1;
        chk("midop_rst_ready", int'(bus.Op_Ready_O), 1);
        chk("midop_rst_stall", int'(bus.Stall_O), 0);
        chk("midop_rst_func", int'(bus.MMU_Func_O), 0);
        @(negedge Clk); #1; Reset_N = 1'b1;
        bus.MMU_Ack_I = 1'b1;
        @(posedge Clk); #1; bus.MMU_Ack_I = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge Clk);
            chk("post_rst_done", int'(bus.Done_O), 0);
            chk("post_rst_entry", int'(bus.Cp0_LoadEntry_O), 0);
        end

        chk("sb_drain", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
